sr_ff_bank: RTL and testbench

SR_FF_BANK -- requirements
Module: sr_ff_bank

---
 rtl/sr_ff_bank.sv | 107 ++++++++++
 tb/tb_sr_ff_bank.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH independent clocked SR flip-flops with configurable s&r collision policy and a saturating collision counter.
// Define SR_FF_BANK_SYNC_EN to pass s, r and en through 2-flop synchronizers (3-cycle input-to-output latency).
module sr_ff_bank #(
    parameter int unsigned      WIDTH         = 8,
    parameter int unsigned      CONFLICT_MODE = 2,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] conflict,
    output logic [7:0]       conflict_cnt
);

    localparam int unsigned      CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] s_eff;
    logic [WIDTH-1:0] r_eff;
    logic             en_eff;

`ifdef SR_FF_BANK_SYNC_EN
    logic [WIDTH-1:0] s_meta, s_sync;
    logic [WIDTH-1:0] r_meta, r_sync;
    logic             en_meta, en_sync;

    // Two-stage synchronizers for the request and enable inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_meta  <= '0;
            s_sync  <= '0;
            r_meta  <= '0;
            r_sync  <= '0;
            en_meta <= 1'b0;
            en_sync <= 1'b0;
        end else begin
            s_meta  <= s;
            s_sync  <= s_meta;
            r_meta  <= r;
            r_sync  <= r_meta;
            en_meta <= en;
            en_sync <= en_meta;
        end
    end

    assign s_eff  = s_sync;
    assign r_eff  = r_sync;
    assign en_eff = en_sync;
`else
    assign s_eff  = s;
    assign r_eff  = r;
    assign en_eff = en;
`endif

    logic [WIDTH-1:0] both_c;
    logic [WIDTH-1:0] set_only_c;
    logic [WIDTH-1:0] rst_only_c;
    logic [WIDTH-1:0] q_upd_c;
    logic [WIDTH-1:0] q_nxt_c;
    logic             collide_c;

    // Per-channel next state; collisions resolved by CONFLICT_MODE
    always_comb begin
        both_c     = s_eff & r_eff;
        set_only_c = s_eff & ~r_eff;
        rst_only_c = r_eff & ~s_eff;
        q_upd_c    = (q | set_only_c) & ~rst_only_c;
        case (CONFLICT_MODE)
            0:       q_upd_c = (q | set_only_c) & ~rst_only_c;
            1:       q_upd_c = (q | s_eff) & ~rst_only_c;
            3:       q_upd_c = ((q | set_only_c) & ~rst_only_c) ^ both_c;
            default: q_upd_c = (q | set_only_c) & ~r_eff;
        endcase
        q_nxt_c   = en_eff ? q_upd_c : q;
        collide_c = en_eff & (|both_c);
    end

    // Channel state; qb is registered alongside q so both switch on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q        <= RESET_VAL;
            qb       <= ~RESET_VAL;
            conflict <= '0;
        end else begin
            q        <= q_nxt_c;
            qb       <= ~q_nxt_c;
            conflict <= en_eff ? both_c : '0;
        end
    end

    // Saturating collision-cycle counter; clear has priority over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (clr_cnt) begin
            conflict_cnt <= '0;
        end else if (collide_c && (conflict_cnt != CNT_MAX)) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed-vector bench for sr_ff_bank: reset-dominant instance plus a toggle-mode instance on shared stimulus.
module tb_sr_ff_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] s;
    logic [7:0] r;
    logic       clr_cnt;

    logic [7:0] q2, qb2, conflict2, cnt2;
    logic [7:0] q3, qb3, conflict3, cnt3;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    sr_ff_bank #(.WIDTH(8), .CONFLICT_MODE(2), .RESET_VAL(8'h00)) dut_rd (
        .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .clr_cnt(clr_cnt),
        .q(q2), .qb(qb2), .conflict(conflict2), .conflict_cnt(cnt2)
    );

    sr_ff_bank #(.WIDTH(8), .CONFLICT_MODE(3), .RESET_VAL(8'h00)) dut_tg (
        .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .clr_cnt(clr_cnt),
        .q(q3), .qb(qb3), .conflict(conflict3), .conflict_cnt(cnt3)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Drive one vector at the falling edge, then sample just after the next rising edge
    task automatic step(input logic [7:0] s_v, input logic [7:0] r_v, input logic en_v, input logic clr_v);
        @(negedge clk);
        s = s_v;
        r = r_v;
        en = en_v;
        clr_cnt = clr_v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        s = '0;
        r = '0;
        clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_q", q2, 8'h00);
        chk("reset_qb", qb2, 8'hFF);
        chk("reset_conflict", conflict2, 8'h00);
        chk("reset_cnt", cnt2, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef SR_FF_BANK_SYNC_EN
        step(8'h01, 8'h00, 1'b1, 1'b0);
        chk("sync_edge1_q", q2, 8'h00);
        step(8'h01, 8'h00, 1'b1, 1'b0);
        chk("sync_edge2_q", q2, 8'h00);
        step(8'h01, 8'h00, 1'b1, 1'b0);
        chk("sync_edge3_q", q2, 8'h01);
        chk("sync_edge3_qb", qb2, 8'hFE);
        step(8'h81, 8'h81, 1'b1, 1'b0);
        chk("sync_coll_edge1_cnt", cnt2, 8'h00);
        step(8'h00, 8'h00, 1'b1, 1'b0);
        chk("sync_coll_edge2_cnt", cnt2, 8'h00);
        step(8'h00, 8'h00, 1'b1, 1'b0);
        chk("sync_coll_edge3_cnt", cnt2, 8'h01);
        chk("sync_coll_edge3_q", q2, 8'h00);
        chk("sync_coll_edge3_conflict", conflict2, 8'h81);
        chk("sync_tg_q", q3, 8'h80);
`else
        // Set, then reset, then disabled request
        step(8'h0F, 8'h00, 1'b1, 1'b0);
        chk("set_q", q2, 8'h0F);
        step(8'h00, 8'h03, 1'b1, 1'b0);
        chk("reset_bits_q", q2, 8'h0C);
        chk("reset_bits_qb", qb2, 8'hF3);
        step(8'hFF, 8'h00, 1'b0, 1'b0);
        chk("en0_hold_q", q2, 8'h0C);
        chk("en0_conflict", conflict2, 8'h00);
        chk("en0_tg_q", q3, 8'h0C);

        // Establish q=01, then collide on channels 0 and 7
        step(8'h01, 8'hFE, 1'b1, 1'b0);
        chk("preload_q", q2, 8'h01);
        chk("preload_tg_q", q3, 8'h01);
        step(8'h81, 8'h81, 1'b1, 1'b0);
        chk("rdom_q", q2, 8'h00);
        chk("rdom_conflict", conflict2, 8'h81);
        chk("rdom_cnt", cnt2, 8'h01);
        chk("toggle_q", q3, 8'h80);
        chk("toggle_qb", qb3, 8'h7F);
        step(8'h00, 8'h00, 1'b1, 1'b0);
        chk("conflict_one_cycle", conflict2, 8'h00);
        chk("cnt_hold", cnt2, 8'h01);
        chk("hold_q", q2, 8'h00);

        // Collision on 0/7 must not disturb a plain set on channel 1
        step(8'h83, 8'h81, 1'b1, 1'b0);
        chk("indep_q", q2, 8'h02);
        chk("indep_tg_q", q3, 8'h03);
        chk("indep_cnt", cnt2, 8'h02);
        chk("indep_conflict", conflict2, 8'h81);

        // Async reset mid-cycle with q=FF, then held through a collision edge
        step(8'hFF, 8'h00, 1'b1, 1'b0);
        chk("all_set_q", q2, 8'hFF);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_q", q2, 8'h00);
        chk("async_rst_qb", qb2, 8'hFF);
        chk("async_rst_cnt", cnt2, 8'h00);
        s = 8'hFF;
        r = 8'hFF;
        @(posedge clk);
        #1;
        chk("rst_coll_q", q2, 8'h00);
        chk("rst_coll_conflict", conflict2, 8'h00);
        chk("rst_coll_cnt", cnt2, 8'h00);
        chk("rst_coll_tg_q", q3, 8'h00);
        @(negedge clk);
        s = '0;
        r = '0;
        en = 1'b0;
        rst_n = 1'b1;

        // Collision with en=0 is ignored
        step(8'hFF, 8'hFF, 1'b0, 1'b0);
        chk("en0_coll_cnt", cnt2, 8'h00);
        chk("en0_coll_conflict", conflict2, 8'h00);
        chk("en0_coll_tg_q", q3, 8'h00);

        // Saturation after 300 collision cycles
        for (int i = 1; i <= 300; i++) begin
            step(8'h01, 8'h01, 1'b1, 1'b0);
            if (i == 254) chk("cnt_254", cnt2, 8'd254);
            if (i == 255) chk("cnt_255", cnt2, 8'd255);
        end
        chk("cnt_saturated", cnt2, 8'd255);
        chk("cnt_tg_saturated", cnt3, 8'd255);
        step(8'h01, 8'h01, 1'b1, 1'b1);
        chk("clr_wins_cnt", cnt2, 8'h00);
        chk("clr_wins_conflict", conflict2, 8'h01);
        step(8'h01, 8'h01, 1'b1, 1'b0);
        chk("cnt_after_clr", cnt2, 8'h01);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
